// File: rtl/ram_stream_reader_if.sv
// Downstream vector stream between the RAM reader and its consumer.
// A transfer happens on any cycle where valid and ready are both high.
interface ram_stream_reader_if #(
  parameter int unsigned VEC_WIDTH = 264
);
  logic                 valid;
  logic                 ready;
  logic [VEC_WIDTH-1:0] data;
  logic                 last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader for a 1-cycle-latency RAM. It streams i_len vectors starting at
// i_base_addr through a 2-entry FIFO with a valid/ready handshake.
module ram_stream_reader #(
  parameter int unsigned VEC_WIDTH  = 264,
  parameter int unsigned ARR_DEPTH  = 2048,
  parameter int unsigned ADDR_WIDTH = $clog2(ARR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [VEC_WIDTH-1:0]  i_ram_data,
  ram_stream_reader_if.master   strm
);

  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(ARR_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [ADDR_WIDTH-1:0] next_addr_inc;
  logic [LEN_WIDTH-1:0]  issue_left_q;
  logic [LEN_WIDTH-1:0]  pop_left_q;
  logic                  inflight_q;
  logic [VEC_WIDTH-1:0]  fifo_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic [2:0]            credit;
  logic                  push;
  logic                  pop;
  logic                  issue;

  always_comb begin
    push   = inflight_q;
    pop    = (count_q != 2'd0) && strm.ready;
    // Slots already claimed after this cycle's pop; a new read needs one free.
    credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue  = (state_q == StIssue) && (credit < 3'd2);
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    next_addr_inc = (next_addr_q == LastAddr) ? '0 : next_addr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      next_addr_q  <= '0;
      hold_addr_q  <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            next_addr_q  <= i_base_addr;
            issue_left_q <= i_len;
            pop_left_q   <= i_len;
            busy_q       <= 1'b1;
            if (i_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (issue) begin
            hold_addr_q  <= next_addr_q;
            next_addr_q  <= next_addr_inc;
            issue_left_q <= issue_left_q - LEN_WIDTH'(1);
            if (issue_left_q == LEN_WIDTH'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          // Nothing issues here, so an empty FIFO next cycle means fully drained.
          if (count_d == 2'd0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      inflight_q <= issue;
      if (push) begin
        fifo_q[wr_ptr_q] <= i_ram_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        pop_left_q <= pop_left_q - LEN_WIDTH'(1);
      end
      count_q <= count_d;
    end
  end

  // The address only moves in cycles that actually issue a read.
  assign o_ram_addr = issue ? next_addr_q : hold_addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign strm.valid = (count_q != 2'd0);
  assign strm.data  = fifo_q[rd_ptr_q];
  assign strm.last  = (count_q != 2'd0) && (pop_left_q == LEN_WIDTH'(1));

endmodule
